vga_console_ctrl: RTL and testbench
===================================

// Module: vga_console_ctrl
// PURPOSE
// Terminal-style write sequencer for the text-mode buffer write port. Accepts a byte stream over
// a valid/ready handshake and keeps a cursor. Generates addr_write/char_write/write_enable for the
// text buffer, and handles wrap, newline, backspace, clear-screen and scroll.
// Scrolling uses a ring-buffer row offset (top_row), which the display scanner adds to its row index.
// PARAMETERS
// addr_width  32  width of addr_write; matches the text buffer address width
// COLS        80  characters per row
// ROWS        30  rows per screen
// COL_W       7   cursor column width, >= clog2(COLS)
// ROW_W       5   cursor/top_row width, >= clog2(ROWS)
// PORTS
// clk           in   1           system clock; all logic on posedge
// rst           in   1           synchronous, active-high reset
// in_char       in   8           byte to process (ASCII)
// in_valid      in   1           in_char valid
// in_ready      out  1           controller accepts in_char this cycle
// addr_write    out  addr_width  text buffer write address (registered)
// char_write    out  8           text buffer write data (registered)
// write_enable  out  1           text buffer write strobe (registered)
// top_row       out  ROW_W       physical row shown as screen row 0
// cursor_row    out  ROW_W       logical cursor row (0 = top of screen)
// cursor_col    out  COL_W       cursor column
// busy          out  1           high in any clear state (INIT/CLEAR_ROW/CLEAR_ALL)
// BEHAVIOUR
// - Reset: write_enable=0, addr_write=0, char_write=0, in_ready=0, busy=1, top_row=0, cursor=(0,0), state=INIT.
//   Asserting rst in any state aborts the operation and re-enters INIT.
// - Physical address = ((cursor_row+top_row) mod ROWS)*COLS + cursor_col, zero-extended to addr_width.
// - States:
//   INIT       writes 0x20 to addresses 0..ROWS*COLS-1, one per cycle, then goes to IDLE.
//   IDLE       in_ready=1; handshake = in_valid & in_ready.
//   CLEAR_ROW  writes 0x20 to the COLS addresses of one physical row, then goes to IDLE.
//   CLEAR_ALL  same as INIT; entered from IDLE.
// - in_ready=1 only in IDLE; busy = !IDLE. Every clear takes exactly N cycles for N writes.
// - Latency: a byte accepted at edge k produces its write (if any) with write_enable=1 during cycle k+1.
//   Throughput is 1 byte/cycle while no clear is triggered.
// - Byte decode on accept:
//   0x20..0x7E  write byte at the cursor; col++. If col was COLS-1, perform a newline.
//   0x0A        newline: col=0. If row<ROWS-1, row++; otherwise, bottom-row handling applies.
//   0x0D        col=0; no write.
//   0x08        if col>0, col-- and write 0x20 at the new col; if col==0, no-op (no write).
//   0x0C        top_row=0, cursor=(0,0), enter CLEAR_ALL.
//   other       accepted and discarded; no write, cursor unchanged.
// - Bottom-row handling (row==ROWS-1 on newline) is defined under CONFIGURATION.
// - Arithmetic: top_row and physical row wrap mod ROWS (not mod 2^ROW_W); col never exceeds COLS-1.
// - write_enable is high for exactly one cycle per write; it is low in IDLE cycles with no accepted printable/backspace.
// CONFIGURATION
// Macro VGA_CONSOLE_SCROLL_EN:
// - Defined: bottom-row newline sets top_row = (top_row+1) mod ROWS; cursor_row stays ROWS-1;
//   CLEAR_ROW clears the new bottom line's physical row (old top_row).
// - Undefined: top_row is tied to 0; bottom-row newline sets cursor_row=0 and CLEAR_ROW clears physical row 0.
// - Printable-at-last-column wrap follows the same rule in both configurations.
// TESTING
// 1. Reset, release -> 2400 writes of 0x20, addr 0..2399 consecutive; in_ready=1 on cycle 2401 after release.
// 2. Send 'A' (0x41) at (0,0) -> next cycle: write_enable=1, addr=0, char=0x41; cursor_col=1.
// 3. Send 81 x 0x42 back-to-back -> 81 consecutive writes at addr 0..80; cursor=(1,1); in_ready never drops.
// 4. SCROLL_EN: cursor at row 29, send 0x0A -> top_row=1; 80 writes of 0x20 at addr 0..79;
//    in_ready low 80 cycles; cursor=(29,0); next 'C' is written at addr 0.
//    Without SCROLL_EN -> cursor=(0,0), same 80 writes, top_row=0.
// 5. Backspace: at col 5 -> write 0x20 at col 4, cursor_col=4. At col 0 -> no write, cursor unchanged.
// 6. Assert rst during CLEAR_ROW (write 40) -> writes stop next cycle; after release, full INIT sweep from addr 0, top_row=0.

Source files
------------

// File: rtl/vga_console_ctrl.sv
// vga_console_ctrl
//   Terminal-style write sequencer for a text-mode buffer. It accepts bytes over a
//   valid/ready handshake and keeps a cursor. It drives the buffer write port, and it
//   handles line wrap, newline, carriage return, backspace, clear-screen (0x0C) and
//   end-of-screen newline. Scrolling moves a ring-buffer row offset (top_row), which
//   the display scanner adds to its row index.
//
//   Optional feature: define VGA_CONSOLE_SCROLL_EN to scroll on a newline at the bottom
//   row. Without it the cursor returns to row 0, and top_row stays 0.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   in_char       byte to process (ASCII); qualified by in_valid
//   in_valid      in_char valid
//   in_ready      high only in IDLE; handshake = in_valid & in_ready
//   addr_write    registered text buffer write address
//   char_write    registered text buffer write data
//   write_enable  registered text buffer write strobe
//   top_row       physical row shown as screen row 0
//   cursor_row    logical cursor row (0 = top of screen)
//   cursor_col    cursor column
//   busy          high in any clear state (INIT/CLEAR_ROW/CLEAR_ALL)

module vga_console_ctrl #(
  parameter int unsigned addr_width = 32,
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned COL_W      = 7,
  parameter int unsigned ROW_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_char,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [addr_width-1:0] addr_write,
  output logic [7:0]            char_write,
  output logic                  write_enable,
  output logic [ROW_W-1:0]      top_row,
  output logic [ROW_W-1:0]      cursor_row,
  output logic [COL_W-1:0]      cursor_col,
  output logic                  busy
);

  localparam int unsigned NCELLS = ROWS * COLS;
  localparam int unsigned CNT_W  = $clog2(NCELLS + 1);
  localparam int unsigned RW1    = ROW_W + 1;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_CLEAR_ROW,
    S_CLEAR_ALL
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [addr_width-1:0]   base_q, base_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        top_q, top_d;
  logic                    we_q, we_d;
  logic [addr_width-1:0]   addr_q, addr_d;
  logic [7:0]              char_q, char_d;

  logic [RW1-1:0]          phys_sum;
  logic [addr_width-1:0]   cur_addr;
  logic [addr_width-1:0]   top_base;
  logic [CNT_W-1:0]        clr_len;
  logic                    do_nl;

  always_comb begin
    // Physical row wraps mod ROWS, not mod 2^ROW_W.
    phys_sum = {1'b0, row_q} + {1'b0, top_q};
    if (phys_sum >= RW1'(ROWS)) phys_sum = phys_sum - RW1'(ROWS);
    cur_addr = addr_width'(phys_sum) * addr_width'(COLS) + addr_width'(col_q);
    top_base = addr_width'(top_q) * addr_width'(COLS);
    clr_len  = (state_q == S_CLEAR_ROW) ? CNT_W'(COLS) : CNT_W'(NCELLS);

    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    row_d   = row_q;
    col_d   = col_q;
    top_d   = top_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    char_d  = char_q;
    do_nl   = 1'b0;

    case (state_q)
      S_INIT, S_CLEAR_ROW, S_CLEAR_ALL: begin
        if (cnt_q == clr_len) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          we_d   = 1'b1;
          addr_d = base_q + addr_width'(cnt_q);
          char_d = 8'h20;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (in_valid) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            we_d   = 1'b1;
            addr_d = cur_addr;
            char_d = in_char;
            if (col_q == COL_W'(COLS - 1)) do_nl = 1'b1;
            else                           col_d = col_q + COL_W'(1);
          end else if (in_char == 8'h0A) begin
            do_nl = 1'b1;
          end else if (in_char == 8'h0D) begin
            col_d = '0;
          end else if (in_char == 8'h08) begin
            if (col_q != '0) begin
              col_d  = col_q - COL_W'(1);
              we_d   = 1'b1;
              addr_d = cur_addr - addr_width'(1);
              char_d = 8'h20;
            end
          end else if (in_char == 8'h0C) begin
            top_d   = '0;
            row_d   = '0;
            col_d   = '0;
            base_d  = '0;
            state_d = S_CLEAR_ALL;
            we_d    = 1'b1;
            addr_d  = '0;
            char_d  = 8'h20;
            cnt_d   = CNT_W'(1);
          end
        end

        if (do_nl) begin
          col_d = '0;
          if (row_q != ROW_W'(ROWS - 1)) begin
            row_d = row_q + ROW_W'(1);
          end else begin
`ifdef VGA_CONSOLE_SCROLL_EN
            base_d = top_base;
            top_d  = (top_q == ROW_W'(ROWS - 1)) ? '0 : top_q + ROW_W'(1);
`else
            row_d  = '0;
            base_d = '0;
`endif
            state_d = S_CLEAR_ROW;
            // The first clear write is issued on the accept edge. If that edge already
            // carries the wrapped character, the clear starts one cycle later instead.
            if (we_d) begin
              cnt_d = '0;
            end else begin
              we_d   = 1'b1;
              addr_d = base_d;
              char_d = 8'h20;
              cnt_d  = CNT_W'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      base_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      top_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      char_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      row_q   <= row_d;
      col_q   <= col_d;
      top_q   <= top_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      char_q  <= char_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign addr_write   = addr_q;
  assign char_write   = char_q;
  assign write_enable = we_q;
  assign top_row      = top_q;
  assign cursor_row   = row_q;
  assign cursor_col   = col_q;

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Directed bench for vga_console_ctrl in the default build (no scrolling).

module tb_vga_console_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  in_char;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] addr_write;
  logic [7:0]  char_write;
  logic        write_enable;
  logic [4:0]  top_row;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int nw;
  int cyc;

  vga_console_ctrl #(
    .addr_width(32),
    .COLS(80),
    .ROWS(30),
    .COL_W(7),
    .ROW_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_char(in_char),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .addr_write(addr_write),
    .char_write(char_write),
    .write_enable(write_enable),
    .top_row(top_row),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one edge; returns 1 time unit after that edge.
  task automatic send(input logic [7:0] b);
    in_char  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_char  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",    32'(write_enable), 0);
    chk("rst_addr",  addr_write,        0);
    chk("rst_char",  32'(char_write),   0);
    chk("rst_ready", 32'(in_ready),     0);
    chk("rst_busy",  32'(busy),         1);
    chk("rst_top",   32'(top_row),      0);
    chk("rst_row",   32'(cursor_row),   0);
    chk("rst_col",   32'(cursor_col),   0);
    rst = 1'b0;

    // Power-up sweep: 2400 blanks at consecutive addresses.
    for (int i = 0; i < 2400; i++) begin
      @(posedge clk); #1;
      chk("init_we",    32'(write_enable), 1);
      chk("init_addr",  addr_write,        i);
      chk("init_char",  32'(char_write),   32'h20);
      chk("init_ready", 32'(in_ready),     0);
    end
    @(posedge clk); #1;
    chk("init_done_ready", 32'(in_ready),     1);
    chk("init_done_we",    32'(write_enable), 0);
    chk("init_done_busy",  32'(busy),         0);

    // Single printable at (0,0).
    send(8'h41);
    chk("a_we",   32'(write_enable), 1);
    chk("a_addr", addr_write,        0);
    chk("a_char", 32'(char_write),   32'h41);
    chk("a_col",  32'(cursor_col),   1);
    @(posedge clk); #1;
    chk("idle_we", 32'(write_enable), 0);

    // Carriage return: no write, column back to 0.
    send(8'h0D);
    chk("cr_we",  32'(write_enable), 0);
    chk("cr_col", 32'(cursor_col),   0);

    // 81 back-to-back printables wrap into row 1.
    in_char  = 8'h42;
    in_valid = 1'b1;
    for (int i = 0; i < 81; i++) begin
      @(posedge clk); #1;
      if (i == 80) in_valid = 1'b0;
      chk("b_we",    32'(write_enable), 1);
      chk("b_addr",  addr_write,        i);
      chk("b_char",  32'(char_write),   32'h42);
      chk("b_ready", 32'(in_ready),     1);
    end
    chk("b_row", 32'(cursor_row), 1);
    chk("b_col", 32'(cursor_col), 1);

    // Backspace at column 5 of row 1, then at column 0.
    for (int i = 0; i < 4; i++) send(8'h78);
    chk("x_col", 32'(cursor_col), 5);
    send(8'h08);
    chk("bs_we",   32'(write_enable), 1);
    chk("bs_addr", addr_write,        84);
    chk("bs_char", 32'(char_write),   32'h20);
    chk("bs_col",  32'(cursor_col),   4);
    send(8'h0D);
    send(8'h08);
    chk("bs0_we",  32'(write_enable), 0);
    chk("bs0_col", 32'(cursor_col),   0);
    chk("bs0_row", 32'(cursor_row),   1);

    // Unrecognised control byte is swallowed.
    send(8'h01);
    chk("other_we",    32'(write_enable), 0);
    chk("other_row",   32'(cursor_row),   1);
    chk("other_col",   32'(cursor_col),   0);
    chk("other_ready", 32'(in_ready),     1);

    // Walk to the bottom row, then newline at the bottom clears physical row 0.
    for (int i = 0; i < 28; i++) send(8'h0A);
    chk("nl_row", 32'(cursor_row), 29);
    chk("nl_we",  32'(write_enable), 0);
    send(8'h0A);
    for (int i = 0; i < 80; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      chk("row_clr_we",    32'(write_enable), 1);
      chk("row_clr_addr",  addr_write,        i);
      chk("row_clr_char",  32'(char_write),   32'h20);
      chk("row_clr_ready", 32'(in_ready),     0);
    end
    @(posedge clk); #1;
    chk("row_clr_done_ready", 32'(in_ready),     1);
    chk("row_clr_done_we",    32'(write_enable), 0);
    chk("row_clr_row",        32'(cursor_row),   0);
    chk("row_clr_col",        32'(cursor_col),   0);
    chk("row_clr_top",        32'(top_row),      0);
    send(8'h43);
    chk("c_we",   32'(write_enable), 1);
    chk("c_addr", addr_write,        0);
    chk("c_char", 32'(char_write),   32'h43);

    // Form feed: full clear, cursor home.
    send(8'h0C);
    chk("ff_we",    32'(write_enable), 1);
    chk("ff_addr",  addr_write,        0);
    chk("ff_ready", 32'(in_ready),     0);
    chk("ff_row",   32'(cursor_row),   0);
    chk("ff_col",   32'(cursor_col),   0);
    nw  = 1;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (write_enable === 1'b1) nw++;
    end
    chk("ff_writes", nw,  2400);
    chk("ff_cycles", cyc, 2400);

    // Reset in the middle of a row clear restarts the full sweep.
    for (int i = 0; i < 29; i++) send(8'h0A);
    chk("nl2_row", 32'(cursor_row), 29);
    send(8'h0A);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      chk("abort_addr", addr_write, i);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_we",    32'(write_enable), 0);
    chk("abort_busy",  32'(busy),         1);
    chk("abort_ready", 32'(in_ready),     0);
    chk("abort_top",   32'(top_row),      0);
    chk("abort_row",   32'(cursor_row),   0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reinit_we",   32'(write_enable), 1);
    chk("reinit_addr", addr_write,        0);
    nw  = 1;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (write_enable === 1'b1) nw++;
    end
    chk("reinit_writes", nw,  2400);
    chk("reinit_cycles", cyc, 2400);
    chk("reinit_last",   addr_write, 2399);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
